// File: rtl/max7219_pkg.sv
// Shared MAX7219 display types: stream word, stream sizing and scheduler states.
package max7219_pkg;

  localparam int MATRIX_ROWS = 8;

  typedef logic [15:0] max7219_word_t;

  typedef enum logic [1:0] {
    SHOW    = 2'd0,
    PENDING = 2'd1,
    BLANK   = 2'd2
  } sched_state_e;

  // One 16-bit word per matrix row per display module.
  function automatic int stream_width(input int rows, input int cols);
    return MATRIX_ROWS * rows * cols * $bits(max7219_word_t);
  endfunction

endpackage

// File: rtl/pattern_scheduler_sched_seq_next.sv
// Next content-source index: increments with wrap and skips the filler source.
module sched_seq_next #(
  parameter int NUM_SOURCES   = 5,
  parameter int FILLER_SOURCE = 0,
  localparam int SEL_W        = $clog2(NUM_SOURCES)
) (
  input  logic [SEL_W-1:0] i_Idx,
  output logic [SEL_W-1:0] o_Next
);

  localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_SOURCES - 1);
  localparam logic [SEL_W-1:0] FILLER_IDX = SEL_W'(FILLER_SOURCE);

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
    if (v == LAST_IDX) begin
      return {SEL_W{1'b0}};
    end else begin
      return v + 1'b1;
    end
  endfunction

  logic [SEL_W-1:0] step_s;

  // A single filler index means at most one extra step is ever needed.
  always_comb begin
    step_s = wrap_inc(i_Idx);
    if (step_s == FILLER_IDX) begin
      o_Next = wrap_inc(step_s);
    end else begin
      o_Next = step_s;
    end
  end

endmodule

// File: rtl/pattern_scheduler.sv
// Frame-aligned source scheduler for the MAX7219 driver: filler between content
// sources, blank frames on each transition, dwell or manual advance.
module pattern_scheduler
  import max7219_pkg::*;
#(
  parameter int NUM_SOURCES   = 5,
  parameter int FILLER_SOURCE = 0,
  parameter int DISP_ROWS     = 5,
  parameter int DISP_COLUMNS  = 4,
  parameter int DWELL_CLOCKS  = 268435456,
  parameter int BLANK_FRAMES  = 2,
  localparam int STREAM_W     = stream_width(DISP_ROWS, DISP_COLUMNS),
  localparam int SEL_W        = $clog2(NUM_SOURCES)
) (
  input  logic                                i_Clk,
  input  logic                                r_Rst,
  input  logic [NUM_SOURCES-1:0][STREAM_W-1:0] i_Sources,
  input  logic                                i_Next,
  input  logic                                i_Pause,
  input  logic                                i_FrameDone,
  output logic [STREAM_W-1:0]                 o_MAX7219_DataStream,
  output logic [SEL_W-1:0]                    o_Sel,
  output logic                                o_Busy
);

  localparam int DWELL_W = $clog2(DWELL_CLOCKS);
  localparam int BLANK_W = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;

  localparam logic [SEL_W-1:0]   FILLER_IDX = SEL_W'(FILLER_SOURCE);
  localparam logic [SEL_W-1:0]   FIRST_IDX  = (FILLER_SOURCE == 0) ? SEL_W'(1) : SEL_W'(0);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CLOCKS - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

  sched_state_e     state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] nxt_q, nxt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic             busy_q, busy_d;
  logic             req_s;
  logic             advance_s;
  logic [SEL_W-1:0] nxt_after_s;

  sched_seq_next #(
    .NUM_SOURCES  (NUM_SOURCES),
    .FILLER_SOURCE(FILLER_SOURCE)
  ) u_seq_next (
    .i_Idx (nxt_q),
    .o_Next(nxt_after_s)
  );

  // State and counter registers.
  always_ff @(posedge i_Clk or posedge r_Rst) begin
    if (r_Rst) begin
      state_q <= SHOW;
      sel_q   <= FILLER_IDX;
      nxt_q   <= FIRST_IDX;
      dwell_q <= {DWELL_W{1'b0}};
      blank_q <= {BLANK_W{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      nxt_q   <= nxt_d;
      dwell_q <= dwell_d;
      blank_q <= blank_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: a frame-done pulse coincident with the request is not consumed,
  // so the first blank or new frame always starts whole.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    nxt_d     = nxt_q;
    dwell_d   = dwell_q;
    blank_d   = blank_q;
    advance_s = 1'b0;
    req_s     = i_Next | ((dwell_q == DWELL_LAST) & ~i_Pause);

    case (state_q)
      SHOW: begin
        if (req_s) begin
          dwell_d = {DWELL_W{1'b0}};
          state_d = PENDING;
        end else if (!i_Pause) begin
          dwell_d = dwell_q + 1'b1;
        end else begin
          dwell_d = dwell_q;
        end
      end
      PENDING: begin
        if (i_FrameDone) begin
          if (BLANK_FRAMES == 0) begin
            advance_s = 1'b1;
            state_d   = SHOW;
          end else begin
            blank_d = {BLANK_W{1'b0}};
            state_d = BLANK;
          end
        end else begin
          state_d = PENDING;
        end
      end
      BLANK: begin
        if (i_FrameDone) begin
          if (blank_q == BLANK_LAST) begin
            advance_s = 1'b1;
            dwell_d   = {DWELL_W{1'b0}};
            state_d   = SHOW;
          end else begin
            blank_d = blank_q + 1'b1;
          end
        end else begin
          state_d = BLANK;
        end
      end
      default: begin
        state_d = SHOW;
      end
    endcase

    if (advance_s) begin
      if (sel_q == FILLER_IDX) begin
        sel_d = nxt_q;
        nxt_d = nxt_after_s;
      end else begin
        sel_d = FILLER_IDX;
      end
    end else begin
      sel_d = sel_q;
    end

    busy_d = (state_d != SHOW);
  end

  // Output stream mux; blank frames are all zero.
  always_comb begin
    if (state_q == BLANK) begin
      o_MAX7219_DataStream = {STREAM_W{1'b0}};
    end else begin
      o_MAX7219_DataStream = i_Sources[sel_q];
    end
  end

  assign o_Sel  = sel_q;
  assign o_Busy = busy_q;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Scoreboard bench for pattern_scheduler (BLANK_FRAMES=2 and BLANK_FRAMES=0 instances).
module tb_pattern_scheduler;

  localparam int NS       = 5;
  localparam int SW       = 3;
  localparam int STREAM_W = 8 * 5 * 4 * 16;
  localparam int NW       = STREAM_W / 16;

  logic                        clk;
  logic                        r_Rst;
  logic [NS-1:0][STREAM_W-1:0] i_Sources;
  logic                        i_Next;
  logic                        i_Pause;
  logic                        i_FrameDone;
  logic [STREAM_W-1:0]         stream0, stream1;
  logic [SW-1:0]               sel0, sel1;
  logic                        busy0, busy1;

  logic [15:0] src_word [NS];
  int          exp_q [$];
  int          errors = 0;
  int          checks = 0;
  int          fd_cnt = 0;
  logic        fd_en  = 1'b0;

  pattern_scheduler #(
    .NUM_SOURCES(NS), .FILLER_SOURCE(0), .DISP_ROWS(5), .DISP_COLUMNS(4),
    .DWELL_CLOCKS(20), .BLANK_FRAMES(2)
  ) dut0 (
    .i_Clk(clk), .r_Rst(r_Rst), .i_Sources(i_Sources), .i_Next(i_Next),
    .i_Pause(i_Pause), .i_FrameDone(i_FrameDone),
    .o_MAX7219_DataStream(stream0), .o_Sel(sel0), .o_Busy(busy0)
  );

  pattern_scheduler #(
    .NUM_SOURCES(NS), .FILLER_SOURCE(0), .DISP_ROWS(5), .DISP_COLUMNS(4),
    .DWELL_CLOCKS(20), .BLANK_FRAMES(0)
  ) dut1 (
    .i_Clk(clk), .r_Rst(r_Rst), .i_Sources(i_Sources), .i_Next(i_Next),
    .i_Pause(i_Pause), .i_FrameDone(i_FrameDone),
    .o_MAX7219_DataStream(stream1), .o_Sel(sel1), .o_Busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic logic [SW-1:0] sel_of(input int w);
    return (w == 0) ? sel0 : sel1;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 0) ? busy0 : busy1;
  endfunction

  function automatic logic [STREAM_W-1:0] stream_of(input int w);
    return (w == 0) ? stream0 : stream1;
  endfunction

  function automatic logic [STREAM_W-1:0] pat(input int k);
    logic [15:0] w;
    if (k >= 0 && k < NS) w = src_word[k];
    else w = 16'h0000;
    return {NW{w}};
  endfunction

  task automatic init_sources();
    logic [3:0] n;
    for (int k = 0; k < NS; k++) begin
      n = 4'(k);
      src_word[k] = {n, 4'h0, n, 4'h0};
    end
  endtask

  task automatic set_sources();
    for (int k = 0; k < NS; k++) i_Sources[k] = {NW{src_word[k]}};
  endtask

  // One clock: inputs change 1 time unit after the rising edge; FrameDone every 7 clocks.
  task automatic tick();
    @(posedge clk);
    #1;
    fd_cnt      = (fd_cnt == 6) ? 0 : fd_cnt + 1;
    i_FrameDone = fd_en && (fd_cnt == 6);
  endtask

  // After this, the next rising edge is cycle 1; FrameDone is sampled at cycles 7, 14, 21, ...
  task automatic do_reset();
    r_Rst = 1'b1; i_Next = 1'b0; i_Pause = 1'b0; fd_en = 1'b0;
    repeat (2) tick();
    fd_cnt = 0; fd_en = 1'b1; i_FrameDone = 1'b0;
    r_Rst = 1'b0;
  endtask

  task automatic test_reset();
    r_Rst = 1'b1;
    #2;
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (sel_of(w) !== 3'd0) begin
        errors++; $display("FAIL reset_sel dut%0d got %0d required 0", w, sel_of(w));
      end
      checks++;
      if (busy_of(w) !== 1'b0) begin
        errors++; $display("FAIL reset_busy dut%0d got %0b required 0", w, busy_of(w));
      end
    end
  endtask

  task automatic run_sequence(input int which, input int nblank);
    int seq [9];
    int pulses, budget, expv;
    logic busy_p, fd_p;
    logic [SW-1:0] sel_p;
    logic [STREAM_W-1:0] str_p, exp_str;
    seq = '{1, 0, 2, 0, 3, 0, 4, 0, 1};
    do_reset();
    checks++;
    if (sel_of(which) !== 3'd0) begin
      errors++; $display("FAIL seq%0d_start got %0d required 0", which, sel_of(which));
    end
    foreach (seq[i]) exp_q.push_back(seq[i]);
    pulses = 0; budget = 0;
    while (exp_q.size() > 0 && budget < 3000) begin
      busy_p = busy_of(which); fd_p = i_FrameDone;
      sel_p  = sel_of(which);  str_p = stream_of(which);
      exp_str = (busy_p && pulses > 0) ? {STREAM_W{1'b0}} : pat(int'(sel_p));
      checks++;
      if (str_p !== exp_str) begin
        errors++;
        $display("FAIL seq%0d_data cyc=%0d sel=%0d got %h required %h", which, budget, sel_p,
                 str_p[15:0], exp_str[15:0]);
      end
      tick(); budget++;
      if (fd_p && busy_p) pulses++;
      checks++;
      if (stream_of(which) !== str_p && !fd_p) begin
        errors++;
        $display("FAIL seq%0d_torn cyc=%0d got change without FrameDone required stable", which, budget);
      end
      if (sel_of(which) !== sel_p) begin
        expv = exp_q.pop_front();
        checks++;
        if (int'(sel_of(which)) != expv) begin
          errors++; $display("FAIL seq%0d_sel got %0d required %0d", which, sel_of(which), expv);
        end
        checks++;
        if (pulses != nblank + 1) begin
          errors++;
          $display("FAIL seq%0d_frames got %0d frames in transition required %0d", which, pulses, nblank + 1);
        end
        pulses = 0;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL seq%0d_timeout got %0d pending selections required 0", which, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_next();
    do_reset();
    tick(); tick();
    i_Next = 1'b1; tick(); i_Next = 1'b0;
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL next_busy got %0b required 1", busy0); end
    repeat (17) tick();
    checks++;
    if (sel0 !== 3'd0 || busy0 !== 1'b1) begin
      errors++; $display("FAIL next_wait got sel=%0d busy=%0b required sel=0 busy=1", sel0, busy0);
    end
    tick();
    checks++;
    if (sel0 !== 3'd1 || busy0 !== 1'b0 || stream0 !== pat(1)) begin
      errors++; $display("FAIL next_switch got sel=%0d busy=%0b required sel=1 busy=0", sel0, busy0);
    end
    repeat (19) tick();
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL next_dwell_early got busy=%0b required 0", busy0); end
    tick();
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL next_dwell_restart got busy=%0b required 1", busy0); end
  endtask

  task automatic test_pause();
    int bad;
    do_reset();
    repeat (5) tick();
    i_Pause = 1'b1; bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sel0 !== 3'd0 || busy0 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL pause_hold got %0d changed cycles required 0", bad); end
    i_Pause = 1'b0;
    repeat (14) tick();
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL pause_resume_early got busy=%0b required 0", busy0); end
    tick();
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL pause_resume got busy=%0b required 1", busy0); end
    do_reset();
    i_Pause = 1'b1; tick();
    i_Next = 1'b1; tick(); i_Next = 1'b0;
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL pause_next got busy=%0b required 1", busy0); end
    i_Pause = 1'b0;
  endtask

  task automatic test_ignore_next();
    int bad;
    do_reset();
    tick(); tick();
    i_Next = 1'b1; tick(); i_Next = 1'b0;
    tick();
    i_Next = 1'b1; tick(); i_Next = 1'b0;
    repeat (4) tick();
    i_Next = 1'b1; tick(); i_Next = 1'b0;
    checks++;
    if (stream0 !== {STREAM_W{1'b0}} || busy0 !== 1'b1) begin
      errors++; $display("FAIL ignore_blank got busy=%0b data=%h required busy=1 data=0000", busy0, stream0[15:0]);
    end
    repeat (11) tick();
    checks++;
    if (sel0 !== 3'd1) begin errors++; $display("FAIL ignore_switch got sel=%0d required 1", sel0); end
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (busy0 !== 1'b0 || sel0 !== 3'd1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ignore_single got %0d extra busy cycles required 0", bad); end
    tick();
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL ignore_dwell got busy=%0b required 1", busy0); end
  endtask

  task automatic test_reset_mid_blank();
    src_word[0] = 16'hA5A5; set_sources();
    do_reset();
    tick(); tick();
    i_Next = 1'b1; tick(); i_Next = 1'b0;
    repeat (7) tick();
    checks++;
    if (busy0 !== 1'b1 || stream0 !== {STREAM_W{1'b0}}) begin
      errors++; $display("FAIL rst_blank_setup got busy=%0b data=%h required busy=1 data=0000", busy0, stream0[15:0]);
    end
    r_Rst = 1'b1;
    #2;
    checks++;
    if (sel0 !== 3'd0 || busy0 !== 1'b0 || stream0 !== pat(0)) begin
      errors++;
      $display("FAIL rst_async got sel=%0d busy=%0b data=%h required sel=0 busy=0 data=a5a5", sel0, busy0, stream0[15:0]);
    end
    init_sources(); set_sources();
  endtask

  task automatic test_coincident();
    do_reset();
    repeat (6) tick();
    i_Next = 1'b1; tick(); i_Next = 1'b0;
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL coinc_busy got %0b required 1", busy0); end
    repeat (20) tick();
    checks++;
    if (sel0 !== 3'd0 || busy0 !== 1'b1) begin
      errors++; $display("FAIL coinc_wait got sel=%0d busy=%0b required sel=0 busy=1", sel0, busy0);
    end
    tick();
    checks++;
    if (sel0 !== 3'd1 || busy0 !== 1'b0) begin
      errors++; $display("FAIL coinc_switch got sel=%0d busy=%0b required sel=1 busy=0", sel0, busy0);
    end
  endtask

  initial begin
    r_Rst = 1'b1; i_Next = 1'b0; i_Pause = 1'b0; i_FrameDone = 1'b0;
    init_sources(); set_sources();
    test_reset();
    run_sequence(0, 2);
    test_next();
    test_pause();
    test_ignore_next();
    test_reset_mid_blank();
    test_coincident();
    run_sequence(1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
